// File: rtl/bus_pkg.sv
// Shared types for the burst bus master: FSM state encoding and transfer mode values.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      XFER = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } bm_state_e;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-cycle counter for the burst master: counts while run_i is high, clears on clr_i,
// and flags expire_o on the cycle the count would reach LIMIT.
module bus_wait_timer #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Expiry is combinational so the FSM leaves on exactly the LIMIT-th waiting cycle.
   assign expire_o = run_i && (cnt_q == CW'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (run_i && !expire_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_master_burst.sv
// Burst system-bus master: arbitrates via breq/bgrant, runs 1..2**LEN_W incrementing beats.
// Optional wait timeout (REQ/XFER stall -> ERR) is built when MASTER_TIMEOUT_EN is defined.
module bus_master_burst
   import bus_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              breq,
   input  logic              bgrant,
   output logic              mode,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              valid,
   input  logic              ready,
   input  logic              u_start,
   input  logic              u_mode,
   input  logic [ADDR_W-1:0] u_addr,
   input  logic [LEN_W-1:0]  u_len,
   input  logic [DATA_W-1:0] u_wdata,
   output logic              u_wnext,
   output logic [DATA_W-1:0] u_rdata,
   output logic              u_rvalid,
   output logic              u_busy,
   output logic              u_done,
   output logic              u_err,
   output logic [2:0]        state_show
);

   bm_state_e         state_q, state_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic              rvalid_q, rvalid_d;
   logic              wnext_q, wnext_d;
   logic              beat_done;
   logic              last_beat;
   logic              expire;

   assign beat_done = (state_q == XFER) && ready;
   assign last_beat = (count_q == len_q);

`ifdef MASTER_TIMEOUT_EN
   logic tmr_run;
   logic tmr_clr;

   assign tmr_run = ((state_q == REQ) && !bgrant) || ((state_q == XFER) && !ready);
   assign tmr_clr = ((state_q == REQ) && bgrant) || beat_done ||
                    (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);

   bus_wait_timer #(
      .LIMIT (TIMEOUT_CYC)
   ) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmr_clr),
      .run_i    (tmr_run),
      .expire_o (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // Write data is prefetched: u_wdata is registered when a beat becomes current and
   // u_wnext then asks the user for the following beat, so beats run back to back.
   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d  = state_q;
      mode_d   = mode_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      len_d    = len_q;
      count_d  = count_q;
      rvalid_d = 1'b0;
      wnext_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (u_start) begin
               state_d = REQ;
               mode_d  = u_mode;
               addr_d  = u_addr;
               len_d   = u_len;
               count_d = '0;
               if (u_mode == MODE_WRITE) begin
                  wdata_d = u_wdata;
                  wnext_d = 1'b1;
               end
            end
         end
         REQ: begin
            if (bgrant)      state_d = XFER;
            else if (expire) state_d = ERR;
         end
         XFER: begin
            if (beat_done) begin
               count_d = count_q + LEN_W'(1);
               addr_d  = addr_q + ADDR_W'(1);
               if (mode_q == MODE_READ) begin
                  rdata_d  = rdata;
                  rvalid_d = 1'b1;
               end else if (!last_beat) begin
                  wdata_d = u_wdata;
                  wnext_d = 1'b1;
               end
               if (last_beat)    state_d = DONE;
               else if (!bgrant) state_d = REQ;
            end else if (expire) begin
               state_d = ERR;
            end else if (!bgrant) begin
               state_d = REQ;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mode_q   <= MODE_READ;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         len_q    <= '0;
         count_q  <= '0;
         rvalid_q <= 1'b0;
         wnext_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         state_q  <= state_d;
         mode_q   <= mode_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         len_q    <= len_d;
         count_q  <= count_d;
         rvalid_q <= rvalid_d;
         wnext_q  <= wnext_d;
      end
   end

   assign breq       = (state_q == REQ) || (state_q == XFER);
   assign valid      = (state_q == XFER);
   assign mode       = mode_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;
   assign u_rdata    = rdata_q;
   assign u_rvalid   = rvalid_q;
   assign u_wnext    = wnext_q;
   assign u_busy     = (state_q != IDLE);
   assign u_done     = (state_q == DONE);
   assign u_err      = (state_q == ERR);
   assign state_show = state_q;

endmodule
